// File: rtl/reg_array_pkg.sv
// rtl/reg_array_pkg.sv - shared states and command-field positions for the register-array command front-end
package reg_array_pkg;

    localparam int DATA_W_DEFAULT = 8;

    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_LEN_MSB  = 6;
    localparam int CMD_LEN_LSB  = 5;
    localparam int CMD_RSVD_MSB = 4;

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        RADDR,
        RCAP,
        RSEND
    } state_t;

    // Bits between the address field and the length field must be zero.
    function automatic logic rsvd_bad(input logic [CMD_RSVD_MSB:0] low, input int addr_w);
        return (low >> addr_w) != '0;
    endfunction

endpackage

// File: rtl/reg_array_cmd_ctrl.sv
// rtl/reg_array_cmd_ctrl.sv - byte-stream command decoder driving register-array writes and reads
module reg_array_cmd_ctrl
    import reg_array_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              err
);

    state_t      state;
    logic [1:0]  len_left;
    logic [ADDR_W-1:0] cur_addr;

    assign in_ready = (state == IDLE) || (state == WDATA);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_left  <= '0;
            cur_addr  <= '0;
            we        <= 1'b0;
            addr      <= '0;
            data_in   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            we  <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (rsvd_bad(in_data[CMD_RSVD_MSB:0], ADDR_W)) begin
                            err <= 1'b1;
                        end else begin
                            len_left <= in_data[CMD_LEN_MSB:CMD_LEN_LSB];
                            cur_addr <= in_data[ADDR_W-1:0];
                            if (in_data[CMD_RW_BIT]) begin
                                state <= WDATA;
                            end else begin
                                // addr is presented during RADDR, so load it on entry
                                addr  <= in_data[ADDR_W-1:0];
                                state <= RADDR;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (in_valid) begin
                        we       <= 1'b1;
                        addr     <= cur_addr;
                        data_in  <= in_data;
                        cur_addr <= cur_addr + ADDR_W'(1);
                        len_left <= len_left - 2'd1;
                        if (len_left == 2'd0) begin
                            state <= IDLE;
                        end
                    end
                end
                RADDR: begin
                    state <= RCAP;
                end
                RCAP: begin
                    out_data  <= data_out;
                    out_valid <= 1'b1;
                    state     <= RSEND;
                end
                RSEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        cur_addr  <= cur_addr + ADDR_W'(1);
                        len_left  <= len_left - 2'd1;
                        if (len_left == 2'd0) begin
                            state <= IDLE;
                        end else begin
                            addr  <= cur_addr + ADDR_W'(1);
                            state <= RADDR;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_array_cmd_ctrl.sv
// tb/tb_reg_array_cmd_ctrl.sv - self-checking bench for reg_array_cmd_ctrl with an attached register array
module tb_reg_array_cmd_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    typedef struct {
        int         cyc;
        logic [1:0] a;
        logic [7:0] d;
    } strobe_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       we;
    logic [1:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       busy;
    logic       err;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] arr [DEPTH];
    logic       booted = 1'b0;
    logic [7:0] ref_mem [DEPTH];
    strobe_t    obs_q [$];
    strobe_t    mon_s;
    int         err_seen = 0;
    int         cyc = 0;

    reg_array_cmd_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .we(we), .addr(addr), .data_in(data_in), .data_out(data_out),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!booted) begin
            for (int i = 0; i < DEPTH; i++) arr[i] <= 8'h00;
            booted <= 1'b1;
        end else if (we) begin
            arr[addr] <= data_in;
        end
    end

    assign data_out = arr[addr];

    always @(negedge clk) begin
        if (we) begin
            mon_s.cyc = cyc;
            mon_s.a   = addr;
            mon_s.d   = data_in;
            obs_q.push_back(mon_s);
        end
        if (err) err_seen <= err_seen + 1;
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL in_ready_wait: got %b need 1 (byte %h)", in_ready, b);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] cmd, input logic [31:0] dat);
        int len, start, mark;
        logic [1:0] ea;
        logic [7:0] ed;
        len   = int'(cmd[6:5]) + 1;
        start = int'(cmd[1:0]);
        mark  = obs_q.size();
        send_byte(cmd);
        for (int i = 0; i < len; i++) send_byte(dat[8*i +: 8]);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (obs_q.size() - mark !== len) begin
            n_fail++;
            $display("FAIL wr_strobe_count cmd %h: got %0d need %0d", cmd, obs_q.size() - mark, len);
        end else begin
            for (int i = 0; i < len; i++) begin
                ea = 2'((start + i) % DEPTH);
                ed = dat[8*i +: 8];
                n_cmp++;
                if (obs_q[mark+i].a !== ea || obs_q[mark+i].d !== ed) begin
                    n_fail++;
                    $display("FAIL wr_strobe[%0d] cmd %h: got a=%0d d=%h need a=%0d d=%h",
                             i, cmd, obs_q[mark+i].a, obs_q[mark+i].d, ea, ed);
                end
                if (i > 0) begin
                    n_cmp++;
                    if (obs_q[mark+i].cyc !== obs_q[mark+i-1].cyc + 1) begin
                        n_fail++;
                        $display("FAIL wr_strobe_spacing[%0d]: got %0d cycles need 1", i,
                                 obs_q[mark+i].cyc - obs_q[mark+i-1].cyc);
                    end
                end
            end
        end
        for (int i = 0; i < len; i++) ref_mem[(start + i) % DEPTH] = dat[8*i +: 8];
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_busy_after: got %b need 0", busy);
        end
    endtask

    task automatic read_collect(input logic [7:0] cmd, input int hold);
        int len, start, n, mark, prev_cyc;
        logic [7:0] exp;
        len   = int'(cmd[6:5]) + 1;
        start = int'(cmd[1:0]);
        mark  = obs_q.size();
        prev_cyc = 0;
        for (int i = 0; i < len; i++) begin
            n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            exp = ref_mem[(start + i) % DEPTH];
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                n_fail++;
                $display("FAIL rd_byte[%0d] cmd %h: got v=%b d=%h need v=1 d=%h", i, cmd, out_valid, out_data, exp);
            end
            if (hold == 0 && i > 0) begin
                n_cmp++;
                if (cyc - prev_cyc !== 3) begin
                    n_fail++;
                    $display("FAIL rd_rate[%0d]: got %0d cycles need 3", i, cyc - prev_cyc);
                end
            end
            prev_cyc = cyc;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== exp) begin
                    n_fail++;
                    $display("FAIL rd_hold[%0d] cycle %0d: got v=%b d=%h need v=1 d=%h", i, k, out_valid, out_data, exp);
                end
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
        n = 0;
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || obs_q.size() != mark) begin
            n_fail++;
            $display("FAIL rd_end cmd %h: got busy=%b v=%b strobes=%0d need 0 0 0",
                     cmd, busy, out_valid, obs_q.size() - mark);
        end
    endtask

    task automatic do_read(input logic [7:0] cmd, input int hold);
        send_byte(cmd);
        read_collect(cmd, hold);
    endtask

    task automatic do_bad(input logic [7:0] cmd);
        int mark, e0;
        mark = obs_q.size();
        e0   = err_seen;
        send_byte(cmd);
        n_cmp++;
        if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_cmd %h: got err=%b busy=%b rdy=%b need 1 0 1", cmd, err, busy, in_ready);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_err_width %h: got err=%b need 0", cmd, err);
        end
        @(negedge clk);
        n_cmp++;
        if (err_seen - e0 !== 1 || obs_q.size() != mark) begin
            n_fail++;
            $display("FAIL bad_side %h: got pulses=%0d strobes=%0d need 1 0", cmd, err_seen - e0, obs_q.size() - mark);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({we, addr, data_in, out_valid, out_data, err, busy} !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got we=%b a=%0d di=%h ov=%b od=%h err=%b busy=%b rdy=%b need all 0, rdy 1",
                     we, addr, data_in, out_valid, out_data, err, busy, in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        do_write(8'h81, 32'h0000_00A5);
    endtask

    task automatic test_burst_wrap();
        do_write(8'hE2, 32'h4433_2211);
    endtask

    task automatic test_read_backpressure();
        do_read(8'h20, 5);
    endtask

    task automatic test_malformed();
        do_bad(8'h0C);
        do_write(8'h83, 32'h0000_00C3);
    endtask

    task automatic test_read_after_write();
        int mark;
        mark = obs_q.size();
        send_byte(8'h80);
        send_byte(8'h5A);
        send_byte(8'h00);
        ref_mem[0] = 8'h5A;
        n_cmp++;
        if (obs_q.size() - mark !== 1 || obs_q[mark].a !== 2'd0 || obs_q[mark].d !== 8'h5A) begin
            n_fail++;
            $display("FAIL raw_strobe: got count=%0d need 1 at a=0 d=5a", obs_q.size() - mark);
        end
        read_collect(8'h00, 0);
    endtask

    task automatic test_reset_mid();
        int mark;
        logic [7:0] b1, b2;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        mark = obs_q.size();
        send_byte(8'hE0);
        send_byte(b1);
        send_byte(b2);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({we, addr, data_in, out_valid, out_data, err, busy} !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async: got we=%b a=%0d di=%h ov=%b od=%h err=%b busy=%b need all 0",
                     we, addr, data_in, out_valid, out_data, err, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        ref_mem[0] = b1;
        n_cmp++;
        if (obs_q.size() - mark !== 1 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_after: got strobes=%0d rdy=%b busy=%b need 1 1 0", obs_q.size() - mark, in_ready, busy);
        end
        do_read(8'h20, 0);
    endtask

    task automatic test_random();
        logic [7:0] c;
        int r;
        for (int it = 0; it < 60; it++) begin
            r = int'($urandom_range(0, 9));
            c = 8'($urandom) & 8'hE3;
            if (r == 0) begin
                c[4:2] = 3'($urandom_range(1, 7));
                do_bad(c);
            end else if (r < 5) begin
                c[7] = 1'b1;
                do_write(c, $urandom);
            end else begin
                c[7] = 1'b0;
                do_read(c, int'($urandom_range(0, 3)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_wrap();
        test_read_backpressure();
        test_malformed();
        test_read_after_write();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout need completion");
        $fatal(1, "watchdog");
    end

endmodule
